acorn128_ctrl: RTL

//  Phase sequencer for the bit-serial ACORN-128 datapath (state register + feedback unit).

---
 rtl/acorn128_pkg.sv | 23 ++
 rtl/acorn128_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/acorn128_pkg.sv
// Shared definitions for the ACORN-128 phase sequencer.
// Holds the phase encoding and the fixed step counts of each phase.
package acorn128_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_AD    = 3'd2,
    ST_ENC   = 3'd3,
    ST_FINAL = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int KEY_W       = 128;
  localparam int INIT_STEPS  = 1792;
  localparam int PAD_STEPS   = 256;
  localparam int CA_TAIL     = 128;
  localparam int FINAL_STEPS = 768;
  localparam int TAG_START   = 640;
  // Fixed part of the step counter; large enough for the 1792-step init phase.
  localparam int CNT_BASE_W  = 11;

endpackage

// File: rtl/acorn128_ctrl.sv
// Phase sequencer for the bit-serial ACORN-128 datapath.
// Walks init -> AD absorb -> encrypt -> finalize, one state-update step per
// cycle with step_en high, drives m/ca/cb to the datapath feedback, streams
// ciphertext bits and collects the 128-bit tag from the keystream.
// Optional feature macro: ACORN128_DECRYPT_EN adds a decrypt input.
//
// Input handshake: on a data step din_ready is high; a bit is consumed on a
// rising edge where din_valid && din_ready. While din_ready is high and
// din_valid is low the step is stalled and no state changes. din_ready never
// depends on din_valid. dout/dout_valid have no backpressure.
module acorn128_ctrl
  import acorn128_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key,
  input  logic [KEY_W-1:0] iv,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [LEN_W-1:0] pt_len,
  input  logic             din,
  input  logic             din_valid,
`ifdef ACORN128_DECRYPT_EN
  input  logic             decrypt,
`endif
  input  logic             ks_in,
  output logic             din_ready,
  output logic             step_en,
  output logic             m_out,
  output logic             ca_out,
  output logic             cb_out,
  output logic             dout,
  output logic             dout_valid,
  output logic [KEY_W-1:0] tag,
  output logic             tag_valid,
  output logic             busy,
  output state_t           state_dbg
);

  localparam int CNT_W = CNT_BASE_W + LEN_W;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [KEY_W-1:0]   key_q;
  logic [KEY_W-1:0]   iv_q;
  logic [LEN_W-1:0]   ad_len_q;
  logic [LEN_W-1:0]   pt_len_q;
  logic [CNT_W-1:0]   ad_len_x;
  logic [CNT_W-1:0]   pt_len_x;
  logic               data_step;
  logic               last_step;
  logic               phase_done;
  logic               start_ok;
  logic               enc_m;

  assign ad_len_x   = CNT_W'(ad_len_q);
  assign pt_len_x   = CNT_W'(pt_len_q);
  assign phase_done = step_en & last_step;
  assign start_ok   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign state_dbg  = state_q;

`ifdef ACORN128_DECRYPT_EN
  logic decrypt_q;

  // Mode bit is captured with the rest of the job parameters.
  always_ff @(posedge clk) begin
    if (rst)           decrypt_q <= 1'b0;
    else if (start_ok) decrypt_q <= decrypt;
  end

  // In decrypt mode the recovered plaintext is what gets absorbed.
  assign enc_m = decrypt_q ? (din ^ ks_in) : din;
`else
  assign enc_m = din;
`endif

  // State register: phase transitions, reset returns to IDLE immediately.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Phase decode: is this a data step, and is it the final step of the phase.
  always_comb begin
    data_step = 1'b0;
    last_step = 1'b0;
    case (state_q)
      ST_INIT:  last_step = (cnt_q == CNT_W'(INIT_STEPS - 1));
      ST_AD: begin
        data_step = (cnt_q < ad_len_x);
        last_step = (cnt_q == ad_len_x + CNT_W'(PAD_STEPS - 1));
      end
      ST_ENC: begin
        data_step = (cnt_q < pt_len_x);
        last_step = (cnt_q == pt_len_x + CNT_W'(PAD_STEPS - 1));
      end
      ST_FINAL: last_step = (cnt_q == CNT_W'(FINAL_STEPS - 1));
      default:  ;
    endcase
  end

  // Next-state logic: each phase hands over on its last completed step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start)      state_d = ST_INIT;
      ST_INIT:  if (phase_done) state_d = ST_AD;
      ST_AD:    if (phase_done) state_d = ST_ENC;
      ST_ENC:   if (phase_done) state_d = ST_FINAL;
      ST_FINAL: if (phase_done) state_d = ST_DONE;
      ST_DONE:  if (start)      state_d = ST_INIT;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Datapath controls: step enable, message bit and ca/cb per phase/step.
  always_comb begin
    step_en   = 1'b0;
    m_out     = 1'b0;
    ca_out    = 1'b0;
    cb_out    = 1'b0;
    din_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        step_en = 1'b1;
        ca_out  = 1'b1;
        cb_out  = 1'b1;
        if (cnt_q < CNT_W'(128))       m_out = key_q[cnt_q[6:0]];
        else if (cnt_q < CNT_W'(256))  m_out = iv_q[cnt_q[6:0]];
        else if (cnt_q == CNT_W'(256)) m_out = ~key_q[0];
        else                           m_out = key_q[cnt_q[6:0]];
      end
      ST_AD: begin
        cb_out = 1'b1;
        ca_out = (cnt_q < ad_len_x + CNT_W'(CA_TAIL));
        if (data_step) begin
          din_ready = 1'b1;
          step_en   = din_valid;
          m_out     = din;
        end else begin
          step_en = 1'b1;
          m_out   = (cnt_q == ad_len_x);
        end
      end
      ST_ENC: begin
        cb_out = 1'b0;
        ca_out = (cnt_q < pt_len_x + CNT_W'(CA_TAIL));
        if (data_step) begin
          din_ready = 1'b1;
          step_en   = din_valid;
          m_out     = enc_m;
        end else begin
          step_en = 1'b1;
          m_out   = (cnt_q == pt_len_x);
        end
      end
      ST_FINAL: begin
        step_en = 1'b1;
        ca_out  = 1'b1;
        cb_out  = 1'b1;
      end
      default: ;
    endcase
  end

  // Step counter: cleared on every phase entry, advances only on real steps.
  always_ff @(posedge clk) begin
    if (rst)                     cnt_q <= '0;
    else if (state_d != state_q) cnt_q <= '0;
    else if (step_en)            cnt_q <= cnt_q + CNT_W'(1);
  end

  // Job parameters are captured when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q    <= '0;
      iv_q     <= '0;
      ad_len_q <= '0;
      pt_len_q <= '0;
    end else if (start_ok) begin
      key_q    <= key;
      iv_q     <= iv;
      ad_len_q <= ad_len;
      pt_len_q <= pt_len;
    end
  end

  // Registered outputs: ciphertext stream, tag collection, status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      tag        <= '0;
      tag_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      busy       <= (state_d != ST_IDLE) && (state_d != ST_DONE);
      if (start_ok) begin
        tag       <= '0;
        tag_valid <= 1'b0;
      end
      if ((state_q == ST_ENC) && data_step && din_valid) begin
        dout       <= din ^ ks_in;
        dout_valid <= 1'b1;
      end
      // Steps 640..767 map onto tag bits 0..127 via the low counter bits.
      if ((state_q == ST_FINAL) && (cnt_q >= CNT_W'(TAG_START)))
        tag[cnt_q[6:0]] <= ks_in;
      if ((state_q == ST_FINAL) && phase_done)
        tag_valid <= 1'b1;
    end
  end

endmodule
